load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory.
- Accepts byte, halfword and word loads and stores (RV32I funct3 encoding) through a valid/ready request.
- Converts each request into word reads and writes on the memory port; the memory has no byte enables.
- Sub-word stores are done as read-modify-write. Load results are lane-extracted and sign- or zero-extended.
- Returns one response per request through a valid/ready handshake.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached memory. A word address at or above this value is an access fault.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  32  extended load data; 0 for stores and faults
- resp_err_o  out  1  fault (bad funct3, out of range, misaligned)
- mem_rw_o  out  1  0 = read, 1 = write
- mem_addr_o  out  32  word index, i.e. byte address >> 2
- mem_data_o  out  32  write data
- mem_rdata_i  in  32  read data, valid the cycle after a read is issued

Behaviour:
- Clock and reset: clk_i is the single clock. rst_i is asynchronous, active-high.
- Reset values:
  - State IDLE.
  - req_ready_o = 1; resp_valid_o = 0; resp_rdata_o = 0; resp_err_o = 0.
  - mem_rw_o = 0, mem_addr_o = 0, mem_data_o = 0.
- Reset mid-operation: the request in flight is abandoned and no write is issued after reset. mem_rw_o drops to 0 immediately.
- States: IDLE, READ, MERGE, WRITE, RESP.
- Request handshake:
  - req_ready_o = 1 only in IDLE.
  - Address, funct3, wdata and we are registered on acceptance (cycle T).
- Fault check at T, decided before any memory access:
  - Fault conditions: funct3 not in {000, 001, 010, 100, 101}; store with funct3 100/101; (addr >> 2) >= MEM_WORDS.
  - On fault: go to RESP with err = 1 and rdata = 0. No memory access.
- Load flow:
  - IDLE -> READ (T+1): mem_rw_o = 0, mem_addr_o = word index.
  - READ -> MERGE (T+2): capture mem_rdata_i, extract the lane, extend.
  - MERGE -> RESP: resp_valid_o first high at T+3.
- Store word: IDLE -> WRITE (T+1), mem_rw_o = 1, mem_data_o = wdata. Then RESP, valid at T+2.
- Store byte/half:
  - READ (T+1), then MERGE (T+2): replace the addressed lane(s) of mem_rdata_i with the low bits of wdata.
  - WRITE (T+3), then RESP, valid at T+4.
- Lane selection:
  - Byte lane = addr[1:0].
  - Half lane = addr[1]: lane 0 = bits 15:0, lane 1 = bits 31:16. Little-endian.
- Extension: B and H sign-extend; BU and HU zero-extend.
- RESP: resp_valid_o holds with stable rdata/err until resp_ready_i. On the handshake cycle go to IDLE; req_ready_o is high the following cycle.
- Outside WRITE, mem_rw_o = 0. A harmless read is permitted because the memory has no enable.
- mem_rw_o is high for exactly one cycle per store. It is never high on a faulting request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, is a fault. It gets an err response with no memory access.
- Undefined: the offending low address bits are ignored. Halfword uses addr[1] only; word ignores addr[1:0]. The access proceeds and err is never raised for alignment.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B/H/W/BU/HU.
  - State enum lsu_state_e.
  - Function for word-index extraction.
- Sub-module lsu_align, combinational:
  - Load lane extract/extend: rdata, addr[1:0], funct3 -> result.
  - Store merge: old word, wdata, addr[1:0], funct3 -> merged word.

Test Plan:
- LW at 0x10, memory word 4 = 0xDEADBEEF -> read at T+1 with mem_addr_o = 4; resp at T+3 with rdata 0xDEADBEEF, err 0.
- SB 0xA5 at 0x13 over word 0x11223344 -> write at T+3 of 0xA5223344; resp at T+4. A following LB at 0x13 returns 0xFFFFFFA5; LBU returns 0x000000A5.
- SH 0xBEEF at 0x22 over 0x00000000 -> writes 0xBEEF0000. LH at 0x22 returns 0xFFFFBEEF; LHU returns 0x0000BEEF.
- Faults:
  - LW at 0x1000 with MEM_WORDS = 1024 -> err 1, no mem_rw_o pulse.
  - funct3 = 011 -> err 1.
  - SB with funct3 100 -> err 1.
- LH at 0x21:
  - With LSU_MISALIGN_TRAP_EN -> err 1, no access.
  - Without it -> data from bits 15:0 of word 8, err 0.
- Backpressure and reset:
  - Hold resp_ready_i = 0 for 5 cycles -> resp_valid_o and rdata stable, req_ready_o = 0 throughout.
  - Assert rst_i during the MERGE state of an SB -> no write issued, all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the byte-address to word-index helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP
  } lsu_state_e;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_result,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = old_word[7:0];
    case (addr_lo)
      2'd1:    byte_val = old_word[15:8];
      2'd2:    byte_val = old_word[23:16];
      2'd3:    byte_val = old_word[31:24];
      default: byte_val = old_word[7:0];
    endcase
    half_val = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    case (funct3)
      F3_B:    load_result = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_result = {24'h0, byte_val};
      F3_H:    load_result = {{16{half_val[15]}}, half_val};
      F3_HU:   load_result = {16'h0, half_val};
      default: load_result = old_word;
    endcase
  end

  // Only signed sizes reach the merge path, so funct3[1:0] alone picks byte or half.
  always_comb begin
    store_word = old_word;
    if (funct3[1:0] == 2'b00) begin
      case (addr_lo)
        2'd1:    store_word[15:8]  = wdata[7:0];
        2'd2:    store_word[23:16] = wdata[7:0];
        2'd3:    store_word[31:24] = wdata[7:0];
        default: store_word[7:0]   = wdata[7:0];
      endcase
    end else if (funct3[1:0] == 2'b01) begin
      if (addr_lo[1]) store_word[31:16] = wdata;
      else            store_word[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed memory without byte enables.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_rw_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3;
  logic [15:0] wdata_lo;
  logic        we;

  logic        funct3_ok;
  logic        misaligned;
  logic        fault;
  logic [31:0] load_result;
  logic [31:0] store_word;

  always_comb begin
    funct3_ok = req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    fault = !funct3_ok || (req_we_i && req_funct3_i[2]) || misaligned ||
            (word_index(req_addr_i) >= 32'(MEM_WORDS));
  end

  lsu_align u_align (
    .old_word    (mem_rdata_i),
    .wdata       (wdata_lo),
    .addr_lo     (addr_lo),
    .funct3      (funct3),
    .load_result (load_result),
    .store_word  (store_word)
  );

  // Faults are resolved at acceptance, so a bad request never touches memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr_lo      <= 2'b00;
      funct3       <= 3'b000;
      wdata_lo     <= 16'h0;
      we           <= 1'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 32'h0;
      resp_err_o   <= 1'b0;
      mem_rw_o     <= 1'b0;
      mem_addr_o   <= 32'h0;
      mem_data_o   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_lo     <= req_addr_i[1:0];
            funct3      <= req_funct3_i;
            wdata_lo    <= req_wdata_i[15:0];
            we          <= req_we_i;
            req_ready_o <= 1'b0;
            if (fault) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= 32'h0;
            end else if (req_we_i && (req_funct3_i == F3_W)) begin
              state      <= WRITE;
              mem_rw_o   <= 1'b1;
              mem_addr_o <= word_index(req_addr_i);
              mem_data_o <= req_wdata_i;
            end else begin
              state      <= READ;
              mem_addr_o <= word_index(req_addr_i);
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          if (we) begin
            state      <= WRITE;
            mem_rw_o   <= 1'b1;
            mem_data_o <= store_word;
          end else begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= load_result;
          end
        end
        WRITE: begin
          state        <= RESP;
          mem_rw_o     <= 1'b0;
          resp_valid_o <= 1'b1;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= 32'h0;
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          mem_rw_o    <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, backpressure and
// mid-operation reset sequences, then random requests against a reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_rw_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_rdata_i;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_rw_o     (mem_rw_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory with registered read; a side port preloads it at start-up.
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'h0;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk_i) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_rw_o) mem[mem_addr_o[9:0]] <= mem_data_o;
    mem_rdata_i <= mem[mem_addr_o[9:0]];
  end

  int          cyc = 0;
  int          write_count = 0;
  int          last_wcyc = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_rw_o) begin
      write_count <= write_count + 1;
      last_wcyc   <= cyc;
      last_waddr  <= mem_addr_o;
      last_wdata  <= mem_data_o;
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] ref_mem [0:1023];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model, computed arithmetically from the access rules.
  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (we && f3 >= 3'd4) bad = 1'b1;
    if (addr / 4 >= 1024) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) bad = 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int unsigned boff, hoff;
    boff = (addr % 4) * 8;
    hoff = ((addr / 2) % 2) * 16;
    case (f3)
      3'd0: begin v = (word >> boff) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = (word >> boff) & 32'hFF;
      3'd1: begin v = (word >> hoff) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = (word >> hoff) & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int unsigned boff, hoff;
    boff = (addr % 4) * 8;
    hoff = ((addr / 2) % 2) * 16;
    if (f3 == 3'd0) begin
      mask = 32'hFF << boff;
      return (old & ~mask) | ((wdata & 32'hFF) << boff);
    end else if (f3 == 3'd1) begin
      mask = 32'hFFFF << hoff;
      return (old & ~mask) | ((wdata & 32'hFFFF) << hoff);
    end
    return wdata;
  endfunction

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                               output int lat, output int writes, output logic [31:0] wr_data,
                               output logic [31:0] wr_addr, output int wr_off);
    int w0, t_acc;
    @(negedge clk_i);
    checkOutput("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    t_acc = cyc;
    w0 = write_count;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!resp_valid_o && lat < 20);
    checkOutput("resp_timeout", {31'b0, !resp_valid_o}, 32'd0);
    rdata = resp_rdata_o;
    err = resp_err_o;
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    writes = write_count - w0;
    wr_data = last_wdata;
    wr_addr = last_waddr;
    wr_off = last_wcyc - t_acc + 1;
  endtask

  task automatic runModelTxn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rdata, wr_data, wr_addr, exp_rdata, new_word;
    logic err, exp_err;
    int lat, writes, wr_off, exp_lat;
    exp_err = model_fault(we, f3, addr);
    exp_rdata = 32'h0;
    new_word = 32'h0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin exp_lat = 3; exp_rdata = model_load(ref_mem[addr / 4], f3, addr); end
    else begin
      exp_lat = (f3 == 3'd2) ? 2 : 4;
      new_word = model_store(ref_mem[addr / 4], f3, addr, wdata);
    end
    applyStimulus(we, f3, addr, wdata, rdata, err, lat, writes, wr_data, wr_addr, wr_off);
    checkOutput("rnd_err", {31'b0, err}, {31'b0, exp_err});
    checkOutput("rnd_rdata", rdata, exp_rdata);
    checkOutput("rnd_latency", lat, exp_lat);
    checkOutput("rnd_write_count", writes, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) begin
      checkOutput("rnd_write_data", wr_data, new_word);
      checkOutput("rnd_write_addr", wr_addr, addr / 4);
      checkOutput("rnd_write_cycle", wr_off, exp_lat - 1);
      ref_mem[addr / 4] = new_word;
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_writes;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk_vec(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                                  input int exp_lat, input int exp_writes, input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    v.exp_writes = exp_writes; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rdata, wr_data, wr_addr, word, exp_word;
    logic err;
    int lat, writes, wr_off, w0, waited;
    logic [2:0] f3_pool [13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0] f3;
    logic [31:0] addr;

    // Preload memory and the reference copy while the DUT is held in reset.
    for (int i = 0; i < 1024; i++) begin
      word = (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'h0 : (32'(i) * 32'h01010101 + 32'h13579BDF);
      ref_mem[i] = word;
      @(negedge clk_i);
      pre_we = 1'b1; pre_addr = 10'(i); pre_data = word;
    end
    @(negedge clk_i);
    pre_we = 1'b0;

    checkOutput("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("reset_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata_o, 32'h0);
    checkOutput("reset_resp_err", {31'b0, resp_err_o}, 32'd0);
    checkOutput("reset_mem_rw", {31'b0, mem_rw_o}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset_mem_data", mem_data_o, 32'h0);
    rst_i = 1'b0;

    vecs.push_back(mk_vec("lw_0x10", 0, F3_W, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 0, 32'h0));
    vecs.push_back(mk_vec("sw_0x10", 1, F3_W, 32'h10, 32'h11223344, 0, 32'h0, 2, 1, 32'h11223344));
    vecs.push_back(mk_vec("sb_0x13", 1, F3_B, 32'h13, 32'h123456A5, 0, 32'h0, 4, 1, 32'hA5223344));
    vecs.push_back(mk_vec("lb_0x13", 0, F3_B, 32'h13, 32'h0, 0, 32'hFFFFFFA5, 3, 0, 32'h0));
    vecs.push_back(mk_vec("lbu_0x13", 0, F3_BU, 32'h13, 32'h0, 0, 32'h000000A5, 3, 0, 32'h0));
    vecs.push_back(mk_vec("sh_0x22", 1, F3_H, 32'h22, 32'h7777BEEF, 0, 32'h0, 4, 1, 32'hBEEF0000));
    vecs.push_back(mk_vec("lh_0x22", 0, F3_H, 32'h22, 32'h0, 0, 32'hFFFFBEEF, 3, 0, 32'h0));
    vecs.push_back(mk_vec("lhu_0x22", 0, F3_HU, 32'h22, 32'h0, 0, 32'h0000BEEF, 3, 0, 32'h0));
    vecs.push_back(mk_vec("lw_out_of_range", 0, F3_W, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk_vec("funct3_011", 0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk_vec("store_funct3_100", 1, F3_BU, 32'h10, 32'hFF, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk_vec("sh_0x20", 1, F3_H, 32'h20, 32'h00008123, 0, 32'h0, 4, 1, 32'hBEEF8123));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk_vec("lh_0x21", 0, F3_H, 32'h21, 32'h0, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk_vec("sw_0x12", 1, F3_W, 32'h12, 32'hCAFEF00D, 1, 32'h0, 1, 0, 32'h0));
`else
    vecs.push_back(mk_vec("lh_0x21", 0, F3_H, 32'h21, 32'h0, 0, 32'hFFFF8123, 3, 0, 32'h0));
    vecs.push_back(mk_vec("sw_0x12", 1, F3_W, 32'h12, 32'hCAFEF00D, 0, 32'h0, 2, 1, 32'hCAFEF00D));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, lat, writes, wr_data, wr_addr, wr_off);
      checkOutput({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
      checkOutput({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      checkOutput({vecs[i].name, "_writes"}, writes, vecs[i].exp_writes);
      if (vecs[i].exp_writes == 1) begin
        checkOutput({vecs[i].name, "_wdata"}, wr_data, vecs[i].exp_wdata);
        checkOutput({vecs[i].name, "_waddr"}, wr_addr, vecs[i].addr >> 2);
        checkOutput({vecs[i].name, "_wcycle"}, wr_off, vecs[i].exp_lat - 1);
        ref_mem[vecs[i].addr >> 2] = model_store(ref_mem[vecs[i].addr >> 2], vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      end
    end

    // Backpressure: response must hold steady while resp_ready_i stays low.
    exp_word = model_load(ref_mem[4], F3_W, 32'h10);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_W; req_addr_i = 32'h10;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!resp_valid_o && waited < 20);
    checkOutput("bp_resp_arrives", {31'b0, resp_valid_o}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_resp_valid_held", {31'b0, resp_valid_o}, 32'd1);
      checkOutput("bp_rdata_stable", resp_rdata_o, exp_word);
      checkOutput("bp_err_stable", {31'b0, resp_err_o}, 32'd0);
      checkOutput("bp_req_ready_low", {31'b0, req_ready_o}, 32'd0);
      @(negedge clk_i);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("bp_req_ready_after", {31'b0, req_ready_o}, 32'd1);
    checkOutput("bp_resp_valid_after", {31'b0, resp_valid_o}, 32'd0);

    // Reset during MERGE of a byte store: no write may follow.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_B; req_addr_i = 32'h13; req_wdata_i = 32'h5A;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    w0 = write_count;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst_async_mem_rw", {31'b0, mem_rw_o}, 32'd0);
    checkOutput("rst_async_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_async_mem_data", mem_data_o, 32'h0);
    checkOutput("rst_async_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rst_async_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("rst_async_resp_rdata", resp_rdata_o, 32'h0);
    checkOutput("rst_async_resp_err", {31'b0, resp_err_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    checkOutput("rst_no_write", write_count - w0, 32'd0);
    checkOutput("rst_idle_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    runModelTxn(1'b0, F3_W, 32'h10, 32'h0);

    for (int n = 0; n < 200; n++) begin
      f3 = f3_pool[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0000_1000;
      else addr = 32'($urandom_range(0, 127));
      runModelTxn(1'($urandom_range(0, 1)), f3, addr, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
